// File: rtl/pipemem_pkg.sv
// Shared constants for the MEM-stage responder: address map, peripheral FSM
// states and the default read value returned when a peripheral access times out.
package pipemem_pkg;

  localparam logic [7:0]  RAM_LIMIT      = 8'h7F;
  localparam logic [7:0]  PORT_IN0       = 8'h80;
  localparam logic [7:0]  PORT_IN1       = 8'h84;
  localparam logic [7:0]  PORT_OUT0      = 8'h88;
  localparam logic [7:0]  PORT_OUT1      = 8'h8C;
  localparam logic [7:0]  PORT_OUT2      = 8'h90;
  localparam logic [7:0]  PER_BASE       = 8'hC0;
  localparam logic [5:0]  PER_WORD_BASE  = 6'h30;
  localparam logic [31:0] DEF_TIMEOUT_VAL = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } per_state_t;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for the asynchronous switch inputs.
module io_sync2 #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; the first may go metastable, the second is used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pipemem_io.sv
// MEM-stage responder: data RAM, memory-mapped IO ports and a handshaked
// peripheral. Optional build macro MEM_IO_TIMEOUT_EN adds a REQ watchdog.
//
// state | meaning
// IDLE  | no peripheral access outstanding
// REQ   | per_req asserted, waiting for per_ack (or watchdog expiry)
// DONE  | captured data presented on mmo, stall released for one cycle
module pipemem_io
  import pipemem_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 32,
  parameter int unsigned PER_TIMEOUT = 16,
  parameter logic [31:0] TIMEOUT_VAL = DEF_TIMEOUT_VAL
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic [31:0] mmo,
  output logic        mem_stall,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2,
  output logic        per_req,
  output logic        per_we,
  output logic [5:0]  per_addr,
  output logic [31:0] per_wdata,
  input  logic [31:0] per_rdata,
  input  logic        per_ack,
  output logic        per_timeout
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  per_state_t state_q, state_d;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] in0_s, in1_s;
  logic [31:0] cap_q;
  logic [31:0] rd;
  logic [7:0]  wa;
  logic [RAM_AW-1:0] ram_idx;
  logic in_ram, in_per, per_hit, wr_ok, tmo_hit;
  logic unused_bits;

  // Word-aligned address; byte lanes and upper address bits are ignored.
  assign wa          = {malu[7:2], 2'b00};
  assign ram_idx     = malu[RAM_AW+1:2];
  assign unused_bits = ^{malu[31:8], malu[1:0]};
  assign in_ram      = (wa <= RAM_LIMIT);
  assign in_per      = (wa >= PER_BASE);
  assign per_hit     = in_per & (mwmem | mm2reg);
  // Reset gates the stall so the pipeline is released as soon as reset asserts.
  assign mem_stall   = ~reset & (((state_q == IDLE) & per_hit) | (state_q == REQ));
  assign wr_ok       = mwmem & ~mem_stall;
  assign per_req     = (state_q == REQ);

  io_sync2 #(.W(32)) u_sync0 (.clock(clock), .reset(reset), .d(in_port0), .q(in0_s));
  io_sync2 #(.W(32)) u_sync1 (.clock(clock), .reset(reset), .d(in_port1), .q(in1_s));

  // Data RAM: contents survive reset, so no reset branch here.
  always_ff @(posedge clock) begin
    if (wr_ok & in_ram) ram[ram_idx] <= mb;
  end

  // Output port registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else if (wr_ok) begin
      if (wa == PORT_OUT0) out_port0 <= mb;
      if (wa == PORT_OUT1) out_port1 <= mb;
      if (wa == PORT_OUT2) out_port2 <= mb;
    end
  end

  // Load mux; peripheral region returns captured data only once the access completes.
  always_comb begin
    rd = '0;
    if (in_ram)                rd = ram[ram_idx];
    else if (wa == PORT_IN0)   rd = in0_s;
    else if (wa == PORT_IN1)   rd = in1_s;
    else if (wa == PORT_OUT0)  rd = out_port0;
    else if (wa == PORT_OUT1)  rd = out_port1;
    else if (wa == PORT_OUT2)  rd = out_port2;
    else if (in_per)           rd = (state_q == DONE) ? cap_q : '0;
    mmo = mm2reg ? rd : '0;
  end

  // Peripheral FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Peripheral FSM next state; DONE always returns to IDLE so the held instruction does not re-trigger.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (per_hit) state_d = REQ;
      REQ:     if (per_ack || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request attributes latched on entry to REQ; read data captured on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      cap_q     <= '0;
    end else begin
      if ((state_q == IDLE) && per_hit) begin
        per_we    <= mwmem;
        per_addr  <= wa[7:2] - PER_WORD_BASE;
        per_wdata <= mb;
      end
      if (state_q == REQ) begin
        if (per_ack)      cap_q <= per_rdata;
        else if (tmo_hit) cap_q <= TIMEOUT_VAL;
      end
    end
  end

`ifdef MEM_IO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(PER_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_flag_q;

  assign tmo_hit     = (tmo_cnt_q == '0);
  assign per_timeout = tmo_flag_q;

  // Watchdog down-counter preloaded in IDLE; terminal count on the last allowed REQ cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q == IDLE)
        tmo_cnt_q <= TW'(PER_TIMEOUT - 1);
      else if ((state_q == REQ) && (tmo_cnt_q != '0))
        tmo_cnt_q <= tmo_cnt_q - 1'b1;
      if ((state_q == REQ) && !per_ack && tmo_hit)
        tmo_flag_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign tmo_hit     = 1'b0;
  assign per_timeout = 1'b0;
  assign unused_cfg  = ^32'(PER_TIMEOUT);
`endif

endmodule

// File: tb/tb_pipemem_io.sv
// Directed bench for pipemem_io; build with MEM_IO_TIMEOUT_EN to cover the watchdog.
module tb_pipemem_io;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwmem, mm2reg;
  logic [31:0] malu, mb, mmo;
  logic        mem_stall;
  logic [31:0] in_port0, in_port1;
  logic [31:0] out_port0, out_port1, out_port2;
  logic        per_req, per_we;
  logic [5:0]  per_addr;
  logic [31:0] per_wdata, per_rdata;
  logic        per_ack, per_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  pipemem_io dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mm2reg(mm2reg), .malu(malu), .mb(mb),
    .mmo(mmo), .mem_stall(mem_stall), .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata), .per_ack(per_ack), .per_timeout(per_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic rd, input logic [31:0] a, input logic [31:0] d);
    mwmem = we; mm2reg = rd; malu = a; mb = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; mwmem = 0; mm2reg = 0; malu = 0; mb = 0;
    in_port0 = 32'h0BAD0001; in_port1 = 0; per_rdata = 0; per_ack = 0;
    #12;
    drive(0, 1, 32'h80, 0);
    chk("rst_sync0", mmo, 0);
    chk("rst_out0", out_port0, 0);
    chk("rst_out2", out_port2, 0);
    chk("rst_req", {31'b0, per_req}, 0);
    chk("rst_stall", {31'b0, mem_stall}, 0);
    chk("rst_addr", {26'b0, per_addr}, 0);
    chk("rst_tmo", {31'b0, per_timeout}, 0);
    reset = 1'b0;

    // RAM store/load, including store-then-load of same word next cycle
    drive(1, 0, 32'h08, 32'h11111111); cyc();
    drive(1, 0, 32'hFFFFFF04, 32'h12345678); cyc();
    drive(0, 1, 32'h04, 0);
    chk("ram_ld04", mmo, 32'h12345678);
    drive(0, 1, 32'h0A, 0);
    chk("ram_ld08", mmo, 32'h11111111);
    drive(0, 0, 32'h04, 0);
    chk("mmo_noload", mmo, 0);
    // store and load together: treated as store, mmo shows pre-edge content
    drive(1, 1, 32'h04, 32'h0000AAAA);
    chk("ld_st_old", mmo, 32'h12345678);
    cyc();
    drive(0, 1, 32'h04, 0);
    chk("ld_st_new", mmo, 32'h0000AAAA);

    // Output ports
    drive(1, 0, 32'h88, 32'hA5);
    chk("out0_pre", out_port0, 0);
    cyc();
    chk("out0_post", out_port0, 32'hA5);
    drive(0, 1, 32'h88, 0);
    chk("out0_rb", mmo, 32'hA5);
    drive(1, 0, 32'h8C, 32'h1); cyc();
    drive(1, 0, 32'h90, 32'h2); cyc();
    chk("out1", out_port1, 32'h1);
    chk("out2", out_port2, 32'h2);
    chk("out0_keep", out_port0, 32'hA5);
    drive(1, 0, 32'h80, 32'h99); cyc();
    drive(1, 0, 32'hA0, 32'h77); cyc();
    drive(0, 1, 32'h80, 0);
    chk("in0_ro", mmo, 32'h0BAD0001);
    drive(0, 1, 32'hA0, 0);
    chk("unmapped", mmo, 0);
    chk("unmap_nowr", out_port2, 32'h2);

    // in_port1 synchronizer latency
    drive(0, 1, 32'h84, 0);
    in_port1 = 32'hCAFEF00D; #1;
    chk("in1_n", mmo, 0);
    cyc();
    chk("in1_n1", mmo, 0);
    cyc();
    chk("in1_n2", mmo, 32'hCAFEF00D);

    // Peripheral load @0xC8, ack on third REQ cycle
    drive(0, 1, 32'hC8, 0);
    chk("pl_stall0", {31'b0, mem_stall}, 1);
    chk("pl_req0", {31'b0, per_req}, 0);
    cyc();
    chk("pl_req1", {31'b0, per_req}, 1);
    chk("pl_addr", {26'b0, per_addr}, 2);
    chk("pl_we", {31'b0, per_we}, 0);
    chk("pl_stall1", {31'b0, mem_stall}, 1);
    cyc();
    chk("pl_stall2", {31'b0, mem_stall}, 1);
    cyc();
    per_ack = 1; per_rdata = 32'h55; #1;
    chk("pl_stall3", {31'b0, mem_stall}, 1);
    cyc();
    per_ack = 0; per_rdata = 0; #1;
    chk("pl_done_stall", {31'b0, mem_stall}, 0);
    chk("pl_done_req", {31'b0, per_req}, 0);
    chk("pl_done_mmo", mmo, 32'h55);
    cyc();
    drive(0, 0, 32'h00, 0);
    per_ack = 1; #1;
    chk("stray_ack_stall", {31'b0, mem_stall}, 0);
    cyc();
    per_ack = 0; #1;
    chk("stray_ack_req", {31'b0, per_req}, 0);

    // Peripheral store @0xC4, acked on first REQ cycle: two stall cycles
    drive(1, 0, 32'hC4, 32'h77);
    chk("ps_stall0", {31'b0, mem_stall}, 1);
    cyc();
    per_ack = 1; #1;
    chk("ps_we", {31'b0, per_we}, 1);
    chk("ps_addr", {26'b0, per_addr}, 1);
    chk("ps_wdata", per_wdata, 32'h77);
    chk("ps_stall1", {31'b0, mem_stall}, 1);
    cyc();
    per_ack = 0; #1;
    chk("ps_done_stall", {31'b0, mem_stall}, 0);
    cyc();
    drive(0, 0, 0, 0);

`ifdef MEM_IO_TIMEOUT_EN
    // No ack: abort after 16 REQ cycles
    drive(0, 1, 32'hFC, 0);
    cyc();
    for (int k = 1; k < 16; k++) cyc();
    chk("to_req16_stall", {31'b0, mem_stall}, 1);
    chk("to_req16_flag", {31'b0, per_timeout}, 0);
    cyc();
    chk("to_mmo", mmo, 32'hDEADBEEF);
    chk("to_flag", {31'b0, per_timeout}, 1);
    chk("to_stall", {31'b0, mem_stall}, 0);
    cyc();
    drive(0, 0, 0, 0);
    per_ack = 1; cyc(); per_ack = 0; #1;
    chk("to_sticky", {31'b0, per_timeout}, 1);
    chk("to_late_ack", {31'b0, per_req}, 0);
`else
    // Without the watchdog REQ waits indefinitely
    drive(0, 1, 32'hFC, 0);
    cyc();
    for (int k = 0; k < 20; k++) cyc();
    chk("wait_stall", {31'b0, mem_stall}, 1);
    chk("wait_tmo", {31'b0, per_timeout}, 0);
    per_ack = 1; per_rdata = 32'h3C; cyc();
    per_ack = 0; #1;
    chk("wait_mmo", mmo, 32'h3C);
    cyc();
    drive(0, 0, 0, 0);
`endif

    // Reset asserted mid-REQ
    drive(0, 1, 32'hC0, 0);
    cyc();
    chk("rr_req", {31'b0, per_req}, 1);
    #2 reset = 1'b1; #1;
    chk("rr_req0", {31'b0, per_req}, 0);
    chk("rr_stall0", {31'b0, mem_stall}, 0);
    chk("rr_out0", out_port0, 0);
    chk("rr_out1", out_port1, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1, 32'h04, 0);
    chk("rr_ram", mmo, 32'h0000AAAA);
    drive(0, 1, 32'h08, 0);
    chk("rr_ram08", mmo, 32'h11111111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
